// File: rtl/data_mem_controller.sv
// Data-side memory controller: maps CPU byte/half/word loads and stores onto a
// word-wide synchronous RAM without byte enables (sub-word stores use read-modify-write).
module data_mem_controller #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [1:0]            cpu_size,
    input  logic                  cpu_unsigned,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    output logic                  cpu_misaligned,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        MERGE = 2'b10
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    misaligned_s;
    logic [31:0]             cpu_rdata_s;
    logic                    cpu_stall_s;
    logic                    cpu_misaligned_s;
    logic                    ram_en_s;
    logic                    ram_we_s;
    logic [31:0]             ram_wdata_s;
    logic [ADDR_WIDTH-1:0]   word_addr_s;
    logic                    unused_addr_s;

    // Extract the addressed lane of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   extend_load = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   extend_load = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: extend_load = sh;
        endcase
    endfunction

    // Replace the addressed byte/half lane of a RAM word with the store data low lane.
    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] mask;
        logic [31:0] lane;
        case (size)
            2'b00: begin
                mask = 32'h000000FF << {off, 3'b000};
                lane = {24'h000000, wdata[7:0]} << {off, 3'b000};
            end
            2'b01: begin
                mask = 32'h0000FFFF << {off, 3'b000};
                lane = {16'h0000, wdata[15:0]} << {off, 3'b000};
            end
            default: begin
                mask = 32'hFFFFFFFF;
                lane = wdata;
            end
        endcase
        merge_store = (word & ~mask) | (lane & mask);
    endfunction

    assign word_addr_s   = cpu_addr[ADDR_WIDTH+1:2];
    assign unused_addr_s = ^cpu_addr[31:ADDR_WIDTH+2];

    // Alignment check for the presented request.
    always_comb begin
        case (cpu_size)
            2'b00:   misaligned_s = 1'b0;
            2'b01:   misaligned_s = cpu_addr[0];
            2'b10:   misaligned_s = (cpu_addr[1:0] != 2'b00);
            default: misaligned_s = 1'b1;
        endcase
    end

    // Next-state and strobe decode; the request is held by the pipeline while stalled.
    always_comb begin
        state_next_s     = state_r;
        cpu_rdata_s      = 32'h00000000;
        cpu_stall_s      = 1'b0;
        cpu_misaligned_s = 1'b0;
        ram_en_s         = 1'b0;
        ram_we_s         = 1'b0;
        ram_wdata_s      = 32'h00000000;
        case (state_r)
            IDLE: begin
                if (!cpu_req) begin
                    state_next_s = IDLE;
                end else if (misaligned_s) begin
                    cpu_misaligned_s = 1'b1;
                end else if (cpu_we && (cpu_size == 2'b10)) begin
                    ram_en_s    = 1'b1;
                    ram_we_s    = 1'b1;
                    ram_wdata_s = cpu_wdata;
                end else if (!cpu_we) begin
                    ram_en_s     = 1'b1;
                    cpu_stall_s  = 1'b1;
                    state_next_s = LOAD;
                end else begin
                    ram_en_s     = 1'b1;
                    cpu_stall_s  = 1'b1;
                    state_next_s = MERGE;
                end
            end
            LOAD: begin
                cpu_rdata_s  = extend_load(ram_rdata, cpu_addr[1:0], cpu_size, cpu_unsigned);
                state_next_s = IDLE;
            end
            MERGE: begin
                ram_en_s     = 1'b1;
                ram_we_s     = 1'b1;
                ram_wdata_s  = merge_store(ram_rdata, cpu_addr[1:0], cpu_size, cpu_wdata);
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Outputs are forced to zero the moment reset asserts, abandoning any MERGE write.
    always_comb begin
        if (!reset) begin
            cpu_rdata      = 32'h00000000;
            cpu_stall      = 1'b0;
            cpu_misaligned = 1'b0;
            ram_en         = 1'b0;
            ram_we         = 1'b0;
            ram_addr       = {ADDR_WIDTH{1'b0}};
            ram_wdata      = 32'h00000000;
        end else begin
            cpu_rdata      = cpu_rdata_s;
            cpu_stall      = cpu_stall_s;
            cpu_misaligned = cpu_misaligned_s;
            ram_en         = ram_en_s;
            ram_we         = ram_we_s;
            ram_addr       = ram_en_s ? word_addr_s : {ADDR_WIDTH{1'b0}};
            ram_wdata      = ram_wdata_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller with a behavioural synchronous RAM.
module tb_data_mem_controller;

    localparam int AW = 14;

    logic          clk;
    logic          reset;
    logic          cpu_req;
    logic          cpu_we;
    logic [1:0]    cpu_size;
    logic          cpu_unsigned;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          cpu_misaligned;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [31:0]   mem [0:(1<<AW)-1];
    int            n_checks;
    int            n_fail;

    data_mem_controller #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .cpu_misaligned(cpu_misaligned), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM, read data valid the cycle after a read access.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req = req; cpu_we = we; cpu_size = size; cpu_unsigned = uns;
        cpu_addr = addr; cpu_wdata = wdata;
    endtask

    // {stall, misaligned, ram_en, ram_we} packed for compact strobe checks
    function automatic logic [31:0] strobes();
        return {28'h0000000, cpu_stall, cpu_misaligned, ram_en, ram_we};
    endfunction

    task automatic store_word(input string tag, input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] exp_waddr);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 2'b10, 1'b0, addr, data);
        #1;
        check_eq({tag, " strobes"}, strobes(), 32'h3);
        check_eq({tag, " wdata"}, ram_wdata, data);
        check_eq({tag, " addr"}, {18'h0, ram_addr}, exp_waddr);
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] exp);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, size, uns, addr, 32'h00000000);
        #1;
        check_eq({tag, " c1 strobes"}, strobes(), 32'hA);
        check_eq({tag, " c1 rdata"}, cpu_rdata, 32'h00000000);
        @(posedge clk); #2;
        check_eq({tag, " c2 strobes"}, strobes(), 32'h0);
        check_eq({tag, " c2 rdata"}, cpu_rdata, exp);
    endtask

    task automatic store_sub(input string tag, input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] data, input logic [31:0] exp_word);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, size, 1'b0, addr, data);
        #1;
        check_eq({tag, " c1 strobes"}, strobes(), 32'hA);
        @(posedge clk); #2;
        check_eq({tag, " c2 strobes"}, strobes(), 32'h3);
        check_eq({tag, " c2 wdata"}, ram_wdata, exp_word);
    endtask

    task automatic misaligned(input string tag, input logic we, input logic [1:0] size,
                              input logic [31:0] addr);
        @(posedge clk); #1;
        drive(1'b1, we, size, 1'b0, addr, 32'hDEADBEEF);
        #1;
        check_eq({tag, " strobes"}, strobes(), 32'h4);
        check_eq({tag, " rdata"}, cpu_rdata, 32'h00000000);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h00000100, 32'hFFFFFFFF);
        #3;
        check_eq("reset strobes", strobes(), 32'h0);
        check_eq("reset outs", cpu_rdata | ram_wdata | {18'h0, ram_addr}, 32'h00000000);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h00000000, 32'h00000000);
        reset = 1'b1;
        #1;
        check_eq("idle strobes", strobes(), 32'h0);

        store_word("sw 100", 32'h00000100, 32'h11223344, 32'h40);
        load("lw 100", 32'h00000100, 2'b10, 1'b0, 32'h11223344);
        store_sub("sb 101", 32'h00000101, 2'b00, 32'h000000AB, 32'h1122AB44);
        load("lb 101", 32'h00000101, 2'b00, 1'b0, 32'hFFFFFFAB);
        load("lbu 101", 32'h00000101, 2'b00, 1'b1, 32'h000000AB);
        load("lb 100", 32'h00000100, 2'b00, 1'b0, 32'h00000044);
        store_sub("sh 102", 32'h00000102, 2'b01, 32'h1234BEEF, 32'hBEEFAB44);
        load("lh 102", 32'h00000102, 2'b01, 1'b0, 32'hFFFFBEEF);
        load("lhu 102", 32'h00000102, 2'b01, 1'b1, 32'h0000BEEF);
        load("lw 100 merged", 32'h00000100, 2'b10, 1'b0, 32'hBEEFAB44);

        misaligned("mis lw 102", 1'b0, 2'b10, 32'h00000102);
        misaligned("mis sh 103", 1'b1, 2'b01, 32'h00000103);
        misaligned("mis size3", 1'b0, 2'b11, 32'h00000100);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h00000000, 32'h00000000);
        #1;
        check_eq("post mis idle", strobes(), 32'h0);

        store_word("sw wrap", 32'h00010000, 32'hCAFEF00D, 32'h0);
        store_word("sw 104 b2b", 32'h00000104, 32'h55667788, 32'h41);
        load("lw 0 wrap", 32'h00000000, 2'b10, 1'b0, 32'hCAFEF00D);
        load("lw 104", 32'h00000104, 2'b10, 1'b0, 32'h55667788);

        store_word("sw 100 restore", 32'h00000100, 32'h11223344, 32'h40);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h00000100, 32'h00000055);
        #1;
        check_eq("rst sb c1 strobes", strobes(), 32'hA);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_eq("rst merge strobes", strobes(), 32'h0);
        check_eq("rst merge outs", cpu_rdata | ram_wdata | {18'h0, ram_addr}, 32'h00000000);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h00000000, 32'h00000000);
        reset = 1'b1;
        load("lw 100 after rst", 32'h00000100, 2'b10, 1'b0, 32'h11223344);

        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h00000000, 32'h00000000);
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_controller.md
# data_mem_controller

Data-side memory controller between the CPU core's data-memory port and a word-wide synchronous single-port RAM that has no byte enables. It turns byte, halfword and word loads and stores into RAM cycles. Sub-word stores become read-modify-write sequences, and loads are extracted and sign- or zero-extended. The controller stalls the pipeline while an access is outstanding and flags misaligned requests without touching the RAM.

## Interface
Parameters:
- ADDR_WIDTH, default 14: RAM word-address width. Capacity is 2^ADDR_WIDTH words.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- cpu_req  in  1  access request; held stable by the pipeline while cpu_stall=1
- cpu_we  in  1  1 = store, 0 = load
- cpu_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- cpu_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data; the active lane is the low byte or half
- cpu_rdata  out  32  load result; valid only in the cycle a load completes, 0 otherwise
- cpu_stall  out  1  1 = hold the pipeline; the request is not finished
- cpu_misaligned  out  1  one-cycle pulse for a misaligned or illegal request
- ram_en  out  1  RAM access this cycle
- ram_we  out  1  RAM write (qualified by ram_en)
- ram_addr  out  ADDR_WIDTH  word address = cpu_addr[ADDR_WIDTH+1:2]
- ram_wdata  out  32  RAM write word
- ram_rdata  in  32  RAM read word, valid the cycle after a ram_en=1 / ram_we=0 access

## Operation
- FSM states:
  - IDLE (reset state)
  - LOAD: waiting for read data
  - MERGE: read-modify-write in progress
- Misaligned check, applied in IDLE when cpu_req=1:
  - half with addr[0]=1, word with addr[1:0]≠0, or size=11 is misaligned.
  - Response: cpu_misaligned=1, ram_en=0, cpu_stall=0, FSM stays in IDLE.
- Word store (IDLE):
  - ram_en=1, ram_we=1, ram_wdata=cpu_wdata, cpu_stall=0.
  - FSM stays in IDLE.
- Load (IDLE):
  - ram_en=1, ram_we=0, cpu_stall=1, next state LOAD.
  - In LOAD: lane = ram_rdata shifted right by 8·addr[1:0]; byte or half extended per cpu_unsigned; word passed through.
  - cpu_rdata = that result, cpu_stall=0, next state IDLE.
- Sub-word store (IDLE):
  - ram_en=1, ram_we=0, cpu_stall=1, next state MERGE.
  - In MERGE: ram_wdata = ram_rdata with the selected byte or half lane replaced by the cpu_wdata low lane.
  - ram_en=1, ram_we=1, cpu_stall=0, next state IDLE.
- Address bits above ADDR_WIDTH+1 are ignored; accesses wrap modulo RAM size.
- cpu_req=0 in IDLE: all RAM and CPU strobes are 0.
- cpu_req/cpu_we/cpu_size/cpu_addr sampled in LOAD or MERGE are the held values of the original request; no new request is accepted until IDLE.

## Timing
- Reset values (asserted immediately and asynchronously, and held while reset=0):
  - state=IDLE
  - cpu_rdata=0, cpu_stall=0, cpu_misaligned=0
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0
- Reset asserted in LOAD or MERGE abandons the access. In particular, no write is issued from MERGE, so RAM contents are unchanged.
- Latencies:
  - word store: 1 cycle, 0 stall
  - load: 2 cycles, 1 stall
  - sub-word store: 2 cycles, 1 stall
  - misaligned request: 1 cycle, 0 stall
- cpu_stall is combinational from state and request; it is high only in the first cycle of a load or sub-word store.
- Back-to-back requests:
  - A request presented in the cycle after completion is accepted in IDLE with no bubble.
  - Consecutive word stores issue one write per cycle.
- Load immediately after a sub-word store to the same word returns the merged value, because the RAM write completes before the read.

## Test plan
- Word store then load: store 0x11223344 at 0x100, then word load at 0x100 -> one stall cycle, cpu_rdata=0x11223344.
- Byte store: sb 0xAB at 0x101 -> RAM read, then write of 0x1122AB44 with one stall. lb 0x101 -> 0xFFFFFFAB; lbu 0x101 -> 0x000000AB.
- Half store: sh 0xBEEF at 0x102 -> word becomes 0xBEEFAB44. lh 0x102 -> 0xFFFFBEEF; lhu -> 0x0000BEEF.
- Misaligned: lw 0x102, sh 0x103, size=11 -> each gives a cpu_misaligned pulse, ram_en=0 throughout, cpu_stall=0.
- Wrap-around: ADDR_WIDTH=14, store at byte address 0x10000 -> ram_addr=0; readback through 0x0 matches.
- Reset mid-op: sb 0x55 at 0x100, with reset pulled low during MERGE -> no ram_we; all outputs 0 at once; after release, lw 0x100 returns the unchanged 0x11223344.
